// File: rtl/block_slider.sv
// Sliding-block gameplay FSM: bounces the active block, trims it on drop, paces levels.
// Optional PERFECT_SNAP_EN: a drop within one pixel of the tower top keeps the full block.
module block_slider #(
   parameter int SCREEN_W   = 160,
   parameter int X_W        = 8,
   parameter int INIT_WIDTH = 40,
   parameter int START_DIFF = 8,
   parameter int MIN_DIFF   = 1,
   parameter int MAX_LEVEL  = 31
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           tick,
   input  logic           start,
   input  logic           drop,
   output logic [X_W-1:0] x_pos,
   output logic [X_W-1:0] width,
   output logic [X_W-1:0] base_x,
   output logic [X_W-1:0] base_w,
   output logic [4:0]     level,
   output logic [4:0]     difficulty,
   output logic           speed_load,
   output logic           placed,
   output logic           game_over,
   output logic           won
);
   typedef enum logic [2:0] {IDLE, SLIDE, PLACE, NEXT, OVER} state_t;

   localparam logic [X_W-1:0] ONE     = X_W'(1);
   localparam logic [X_W-1:0] INIT_W  = X_W'(INIT_WIDTH);
   localparam logic [X_W-1:0] INIT_BX = X_W'((SCREEN_W - INIT_WIDTH) / 2);
   localparam logic [X_W:0]   SCR     = (X_W + 1)'(SCREEN_W);
   localparam logic [4:0]     START_D = 5'(START_DIFF);
   localparam logic [4:0]     MIN_D   = 5'(MIN_DIFF);
   localparam logic [5:0]     MAX_L   = 6'(MAX_LEVEL);

   state_t         state, state_n;
   logic           dir, dir_n;
   logic [X_W-1:0] x_n, w_n, bx_n, bw_n;
   logic [4:0]     lvl_n, diff_n;
   logic           load_n, placed_n, won_n;

   logic [X_W:0]   right_end, base_end, ovl_r;
   logic [X_W-1:0] ovl_l, ovl_w;
   logic [5:0]     lvl_inc;
   logic           hit;

   assign right_end = {1'b0, x_pos} + {1'b0, width};
   assign base_end  = {1'b0, base_x} + {1'b0, base_w};
   assign ovl_l     = (x_pos > base_x) ? x_pos : base_x;
   assign ovl_r     = (right_end < base_end) ? right_end : base_end;
   assign hit       = ovl_r > {1'b0, ovl_l};
   assign ovl_w     = ovl_r[X_W-1:0] - ovl_l;
   assign lvl_inc   = {1'b0, level} + 6'd1;
   assign game_over = (state == OVER);

`ifdef PERFECT_SNAP_EN
   logic [X_W-1:0] dist;
   logic           perfect;
   assign dist    = (x_pos >= base_x) ? x_pos - base_x : base_x - x_pos;
   assign perfect = dist <= ONE;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         dir        <= 1'b1;
         x_pos      <= '0;
         width      <= INIT_W;
         base_x     <= INIT_BX;
         base_w     <= INIT_W;
         level      <= '0;
         difficulty <= START_D;
         speed_load <= 1'b0;
         placed     <= 1'b0;
         won        <= 1'b0;
      end else begin
         state      <= state_n;
         dir        <= dir_n;
         x_pos      <= x_n;
         width      <= w_n;
         base_x     <= bx_n;
         base_w     <= bw_n;
         level      <= lvl_n;
         difficulty <= diff_n;
         speed_load <= load_n;
         placed     <= placed_n;
         won        <= won_n;
      end
   end

   always_comb begin
      state_n  = state;
      dir_n    = dir;
      x_n      = x_pos;
      w_n      = width;
      bx_n     = base_x;
      bw_n     = base_w;
      lvl_n    = level;
      diff_n   = difficulty;
      load_n   = 1'b0;
      placed_n = 1'b0;
      won_n    = won;
      unique case (state)
         IDLE, OVER: begin
            if (start) begin
               state_n = SLIDE;
               dir_n   = 1'b1;
               x_n     = '0;
               w_n     = INIT_W;
               bx_n    = INIT_BX;
               bw_n    = INIT_W;
               lvl_n   = '0;
               diff_n  = START_D;
               load_n  = 1'b1;
               won_n   = 1'b0;
            end
         end
         SLIDE: begin
            // drop wins over a coincident tick so the block lands where it was seen
            if (drop) begin
               state_n = PLACE;
            end else if (tick) begin
               if (dir) begin
                  if (right_end == SCR) begin
                     dir_n = 1'b0;
                     x_n   = x_pos - ONE;
                  end else begin
                     x_n = x_pos + ONE;
                  end
               end else if (x_pos == '0) begin
                  dir_n = 1'b1;
                  x_n   = ONE;
               end else begin
                  x_n = x_pos - ONE;
               end
            end
         end
         PLACE: begin
`ifdef PERFECT_SNAP_EN
            if (perfect) begin
               placed_n = 1'b1;
               state_n  = NEXT;
            end else
`endif
            if (hit) begin
               bx_n     = ovl_l;
               bw_n     = ovl_w;
               placed_n = 1'b1;
               state_n  = NEXT;
            end else begin
               won_n   = 1'b0;
               state_n = OVER;
            end
         end
         NEXT: begin
            lvl_n = lvl_inc[4:0];
            if (lvl_inc == MAX_L) begin
               won_n   = 1'b1;
               state_n = OVER;
            end else begin
               w_n     = base_w;
               x_n     = '0;
               dir_n   = 1'b1;
               load_n  = 1'b1;
               state_n = SLIDE;
               if (difficulty > MIN_D) diff_n = difficulty - 5'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
